debounce_filter: RTL and testbench

DEBOUNCE_FILTER -- requirements
Module: debounce_filter

---
 rtl/debounce_channel.sv | 60 ++++++
 rtl/debounce_filter.sv | 32 +++
 tb/tb_debounce_filter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser chain, stable level and persistence counter.
// Emits registered one-cycle rise/fall pulses aligned with the level change.
module debounce_channel #(
    parameter int   DEBOUNCE_CYCLES = 120000,
    parameter int   SYNC_STAGES     = 2,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   synced;
    logic                   pending;
    logic                   accept;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign pending = synced != stable_q;
    assign accept  = pending && (cnt_q == CNT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
            stable_q <= RESET_LEVEL;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
            rise_q <= accept && !stable_q;
            fall_q <= accept && stable_q;
            // Any edge where the input agrees with the stable level restarts the count,
            // so glitches shorter than DEBOUNCE_CYCLES never get through.
            if (accept) begin
                stable_q <= ~stable_q;
                cnt_q    <= '0;
            end else if (pending) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level_out  = stable_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/debounce_filter.sv
// Multi-channel debouncer for push-buttons and switches; one independent
// debounce_channel per input bit.
module debounce_filter #(
    parameter int                      NUM_CHANNELS    = 1,
    parameter int                      DEBOUNCE_CYCLES = 120000,
    parameter int                      SYNC_STAGES     = 2,
    parameter logic [NUM_CHANNELS-1:0] RESET_LEVEL     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] raw_in,
    output logic [NUM_CHANNELS-1:0] level_out,
    output logic [NUM_CHANNELS-1:0] rise_pulse,
    output logic [NUM_CHANNELS-1:0] fall_pulse
);

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .RESET_LEVEL     (RESET_LEVEL[i])
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .raw_in     (raw_in[i]),
            .level_out  (level_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter: 4 channels, 4-cycle debounce, 2 sync stages,
// plus a second instance with all channels resetting high.
module tb_debounce_filter;

    logic       clock = 1'b0;
    logic       reset, reset_b;
    logic [3:0] raw_in, raw_b;
    logic [3:0] level_out, rise_pulse, fall_pulse;
    logic [3:0] level_b, rise_b, fall_b;
    int         checks = 0;
    int         errors = 0;

    debounce_filter #(
        .NUM_CHANNELS(4), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(4'b0000)
    ) dut (
        .clock(clock), .reset(reset), .raw_in(raw_in),
        .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
    );

    debounce_filter #(
        .NUM_CHANNELS(4), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(4'b1111)
    ) dut_b (
        .clock(clock), .reset(reset_b), .raw_in(raw_b),
        .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        raw_in = 4'b0000;
        repeat (3) tick();
        checks++;
        if (level_out !== 4'b0000 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got lvl=%b r=%b f=%b expected lvl=0000 r=0000 f=0000",
                     level_out, rise_pulse, fall_pulse);
        end
        reset = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            checks++;
            if (level_out !== 4'b0000 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_quiet cyc %0d: got lvl=%b r=%b f=%b expected all 0000",
                         n, level_out, rise_pulse, fall_pulse);
            end
        end
    endtask

    // Step applied before edge k is accepted at edge k+5, i.e. the 6th tick.
    task automatic test_rise_latency();
        logic [3:0] exp_lvl, exp_rise;
        raw_in[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp_lvl  = (n >= 6) ? 4'b0001 : 4'b0000;
            exp_rise = (n == 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (level_out !== exp_lvl || rise_pulse !== exp_rise || fall_pulse !== 4'b0000) begin
                errors++;
                $display("FAIL rise_latency tick %0d: got lvl=%b r=%b f=%b expected lvl=%b r=%b f=0000",
                         n, level_out, rise_pulse, fall_pulse, exp_lvl, exp_rise);
            end
        end
    endtask

    task automatic test_glitch();
        raw_in[1] = 1'b1;
        repeat (3) tick();
        raw_in[1] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (level_out !== 4'b0001 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
                errors++;
                $display("FAIL glitch_reject tick %0d: got lvl=%b r=%b f=%b expected lvl=0001 r=0000 f=0000",
                         n, level_out, rise_pulse, fall_pulse);
            end
        end
    endtask

    task automatic test_toggle();
        int toggle_rises = 0;
        int hold_rises   = 0;
        for (int n = 0; n < 40; n++) begin
            raw_in[2] = ((n >> 1) & 1) == 0;
            tick();
            if (rise_pulse[2] === 1'b1) toggle_rises++;
        end
        raw_in[2] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rise_pulse[2] === 1'b1) hold_rises++;
        end
        checks++;
        if (toggle_rises != 0) begin
            errors++;
            $display("FAIL toggle_rises: got %0d expected 0", toggle_rises);
        end
        checks++;
        if (hold_rises != 1) begin
            errors++;
            $display("FAIL hold_rises: got %0d expected 1", hold_rises);
        end
        checks++;
        if (level_out !== 4'b0101) begin
            errors++;
            $display("FAIL toggle_final_level: got %b expected 0101", level_out);
        end
    endtask

    task automatic test_all_channels();
        logic [3:0] exp_lvl, exp_p;
        raw_in = 4'b0000;
        repeat (10) tick();
        checks++;
        if (level_out !== 4'b0000) begin
            errors++;
            $display("FAIL all_clear_level: got %b expected 0000", level_out);
        end
        raw_in = 4'b1111;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp_lvl = (n >= 6) ? 4'b1111 : 4'b0000;
            exp_p   = (n == 6) ? 4'b1111 : 4'b0000;
            checks++;
            if (level_out !== exp_lvl || rise_pulse !== exp_p || fall_pulse !== 4'b0000) begin
                errors++;
                $display("FAIL all_rise tick %0d: got lvl=%b r=%b f=%b expected lvl=%b r=%b f=0000",
                         n, level_out, rise_pulse, fall_pulse, exp_lvl, exp_p);
            end
        end
        raw_in = 4'b0000;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp_lvl = (n >= 6) ? 4'b0000 : 4'b1111;
            exp_p   = (n == 6) ? 4'b1111 : 4'b0000;
            checks++;
            if (level_out !== exp_lvl || fall_pulse !== exp_p || rise_pulse !== 4'b0000) begin
                errors++;
                $display("FAIL all_fall tick %0d: got lvl=%b r=%b f=%b expected lvl=%b r=0000 f=%b",
                         n, level_out, rise_pulse, fall_pulse, exp_lvl, exp_p);
            end
        end
    endtask

    // Counter reaches 2 after the 4th tick; reset there must throw the count away.
    task automatic test_reset_pending();
        logic [3:0] exp_lvl, exp_rise;
        raw_in = 4'b1000;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (level_out !== 4'b0000 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_pending: got lvl=%b r=%b f=%b expected all 0000",
                     level_out, rise_pulse, fall_pulse);
        end
        reset = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp_lvl  = (n >= 6) ? 4'b1000 : 4'b0000;
            exp_rise = (n == 6) ? 4'b1000 : 4'b0000;
            checks++;
            if (level_out !== exp_lvl || rise_pulse !== exp_rise || fall_pulse !== 4'b0000) begin
                errors++;
                $display("FAIL restart_after_reset tick %0d: got lvl=%b r=%b f=%b expected lvl=%b r=%b f=0000",
                         n, level_out, rise_pulse, fall_pulse, exp_lvl, exp_rise);
            end
        end
    endtask

    task automatic test_reset_level_high();
        reset_b = 1'b0;
        raw_b   = 4'b1111;
        repeat (3) tick();
        checks++;
        if (level_b !== 4'b1111 || rise_b !== 4'b0000 || fall_b !== 4'b0000) begin
            errors++;
            $display("FAIL high_reset_state: got lvl=%b r=%b f=%b expected lvl=1111 r=0000 f=0000",
                     level_b, rise_b, fall_b);
        end
        reset_b = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            checks++;
            if (level_b !== 4'b1111 || rise_b !== 4'b0000 || fall_b !== 4'b0000) begin
                errors++;
                $display("FAIL high_release_quiet cyc %0d: got lvl=%b r=%b f=%b expected lvl=1111 r=0000 f=0000",
                         n, level_b, rise_b, fall_b);
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        reset_b = 1'b0;
        raw_in  = 4'b0000;
        raw_b   = 4'b1111;
        test_reset();
        test_rise_latency();
        test_glitch();
        test_toggle();
        test_all_channels();
        test_reset_pending();
        test_reset_level_high();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
